// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo #(
    parameter int WAIT  = 16,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(WAIT);
    localparam int AW = $clog2(DEPTH);

    localparam logic [TW-1:0] T_FULL = TW'(WAIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(WAIT / 2 - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [AW:0]   P_ONE  = (AW + 1)'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [1:0]    sync_q;
    logic [1:0]    sync_vld_q;
    logic          rx_s;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          armed_q, armed_d;
    logic          par_ok;
    logic          push, bad;
    logic          frame_err_q, overrun_q;
    logic [AW:0]   wptr_q, rptr_q;
    logic [7:0]    mem_q [DEPTH];
    logic          full, empty, pop, wr_en;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
`endif

    assign rx_s = sync_q[1];

    // Two-flop synchronizer; sync_vld_q marks when rx_s reflects the real line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= 2'b11;
            sync_vld_q <= 2'b00;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_ok = ~(^shift_q ^ par_q);
`else
    assign par_ok = 1'b1;
`endif

    // Receiver next-state: start detect, mid-bit sampling, stop check
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        armed_d = armed_q;
        push    = 1'b0;
        bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rx_s) begin
                    if (sync_vld_q[1]) armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = S_START;
                    tmr_d   = T_HALF;
                    armed_d = 1'b0;
                end
            end
            S_START: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - T_ONE;
                end else if (!rx_s) begin
                    state_d = S_DATA;
                    tmr_d   = T_FULL;
                    idx_d   = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - T_ONE;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    tmr_d   = T_FULL;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - T_ONE;
                end else begin
                    par_d   = rx_s;
                    tmr_d   = T_FULL;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - T_ONE;
                end else begin
                    state_d = S_IDLE;
                    if (rx_s && par_ok) begin
                        push    = 1'b1;
                        armed_d = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receiver state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            armed_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && rready;
    assign wr_en = push && (!full || pop);

    // FIFO pointers and one-cycle status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + P_ONE;
            if (pop)   rptr_q <= rptr_q + P_ONE;
            frame_err_q <= bad;
            overrun_q   <= push && full && !pop;
        end
    end

    // FIFO storage; contents are only visible through valid pointers
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= shift_q;
    end

    assign rvalid    = !empty;
    assign rdata     = rvalid ? mem_q[rptr_q[AW-1:0]] : 8'h00;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at WAIT=4, DEPTH=4.
// Define UART_RX_PARITY_EN to also exercise the parity frame format.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rready = 1'b0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       frame_err;
    logic       overrun;

    int n_chk = 0;
    int n_pass = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    int fe0, ov0;
    logic [7:0] exp_b [4];

    uart_rx_fifo #(.WAIT(4), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        repeat (4) tick();
    endtask

    task automatic send_raw(input logic [7:0] d, input logic stp,
                            input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par !== par) $display("unreachable");
`endif
        send_bit(stp);
    endtask

    task automatic send(input logic [7:0] d, input logic stp);
        send_raw(d, stp, ^d);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        reset = 1'b0;
        repeat (4) tick();

        send(8'hA5, 1'b1);
        check("a5_before", 32'(rvalid), 0);
        tick();
        check("a5_valid", 32'(rvalid), 1);
        check("a5_data", 32'(rdata), 32'hA5);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("a5_popped", 32'(rvalid), 0);
        repeat (4) tick();

        fe0 = fe_cnt;
        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        repeat (12) tick();
        check("glitch_valid", 32'(rvalid), 0);
        check("glitch_ferr", 32'(fe_cnt - fe0), 0);
        send(8'hC3, 1'b1);
        tick();
        check("glitch_next", 32'(rdata), 32'hC3);
        rready = 1'b1;
        tick();
        rready = 1'b0;

        fe0 = fe_cnt;
        send(8'h3C, 1'b0);
        tick();
        check("stop0_ferr", 32'(frame_err), 1);
        check("stop0_valid", 32'(rvalid), 0);
        tick();
        check("stop0_pulse", 32'(frame_err), 0);
        check("stop0_count", 32'(fe_cnt - fe0), 1);
        uart_rx = 1'b1;
        repeat (8) tick();

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        tick();
        tick();
        check("ovr_count", 32'(ov_cnt - ov0), 1);
        check("ovr_ferr", 32'(fe_cnt - fe0), 0);
        repeat (3) tick();
        check("ovr_hold", 32'(rdata), 32'h01);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_drain", 32'(rdata), 32'(i));
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
        check("ovr_empty", 32'(rvalid), 0);

        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        send(8'h44, 1'b1);
        ov0 = ov_cnt;
        send(8'h77, 1'b1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        tick();
        check("full_pp_ovr", 32'(ov_cnt - ov0), 0);
        exp_b[0] = 8'h22;
        exp_b[1] = 8'h33;
        exp_b[2] = 8'h44;
        exp_b[3] = 8'h77;
        for (int i = 0; i < 4; i++) begin
            check("full_pp_drain", 32'(rdata), 32'(exp_b[i]));
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
        check("full_pp_empty", 32'(rvalid), 0);

`ifdef UART_RX_PARITY_EN
        fe0 = fe_cnt;
        send_raw(8'h03, 1'b1, 1'b1);
        tick();
        check("par_bad_ferr", 32'(frame_err), 1);
        check("par_bad_valid", 32'(rvalid), 0);
        repeat (4) tick();
        send_raw(8'h03, 1'b1, 1'b0);
        tick();
        check("par_ok_data", 32'(rdata), 32'h03);
        check("par_ok_valid", 32'(rvalid), 1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
`endif

        send(8'h5A, 1'b1);
        tick();
        check("mid_pre", 32'(rvalid), 1);
        uart_rx = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(rvalid), 0);
        check("mid_rst_data", 32'(rdata), 0);
        tick();
        reset = 1'b0;
        fe0 = fe_cnt;
        repeat (20) tick();
        uart_rx = 1'b1;
        repeat (40) tick();
        check("mid_no_push", 32'(rvalid), 0);
        check("mid_no_ferr", 32'(fe_cnt - fe0), 0);
        send(8'hE7, 1'b1);
        tick();
        check("mid_after", 32'(rdata), 32'hE7);
        check("never_both", 32'(both_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter WAIT, default 16: clock cycles per UART bit; legal range 4..65535.
REQ-002 Parameter DEPTH, default 4: receive FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 uart_rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rdata  output  8  byte at the FIFO head (show-ahead).
REQ-007 rvalid  output  1  FIFO non-empty.
REQ-008 rready  input  1  consumer accept; a pop occurs when rvalid && rready.
REQ-009 frame_err  output  1  one-cycle pulse when a frame is discarded for a bad stop bit (or bad parity, see REQ-030).
REQ-010 overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-011 uart_rx SHALL pass through a 2-flop synchronizer; rx_s denotes the synchronizer output.
REQ-012 The receiver FSM SHALL have the states IDLE, START, DATA, STOP (and PARITY when enabled), plus one bit-timer counter of width clog2(WAIT) and one 3-bit bit index.
REQ-013 IDLE -> START on the first cycle rx_s==0; the bit timer loads WAIT/2-1 (integer division).
REQ-014 In START, at timer expiry: if rx_s==0, go to DATA with timer=WAIT-1 and index=0; otherwise return to IDLE with no flag raised (glitch rejection).
REQ-015 In DATA, at each timer expiry, sample rx_s into the shift register LSB-first; after index 7, go to STOP (or PARITY when enabled); otherwise reload the timer with WAIT-1.
REQ-016 In STOP, at timer expiry: if rx_s==1, push the byte; if rx_s==0, pulse frame_err and discard the byte; both cases then go to IDLE.
REQ-017 A pushed byte SHALL appear at rdata/rvalid on the cycle after the stop-bit sample edge (latency 1).
REQ-018 The FIFO SHALL use a circular buffer with clog2(DEPTH)+1-bit pointers; full/empty SHALL be derived from pointer MSB/LSB comparison; wrap-around SHALL be seamless.
REQ-019 A push while full, with no pop in the same cycle, SHALL drop the new byte, pulse overrun, and leave the FIFO contents unchanged.
REQ-020 A push and pop in the same cycle while full SHALL both succeed; no overrun is raised and the count is unchanged.
REQ-021 A push and pop in the same cycle while empty is impossible (rvalid=0); the push SHALL succeed.
REQ-022 rready while empty SHALL be ignored; pointers remain unchanged.
REQ-023 rdata is don't-care while rvalid=0; it SHALL be stable while rvalid && !rready.
REQ-024 frame_err and overrun SHALL never both be asserted in the same cycle.
REQ-025 Back-to-back frames SHALL be received with zero idle bits between stop bit and next start bit.

Reset
REQ-026 Asserting reset in any state SHALL immediately force: FSM=IDLE, synchronizer flops=1, timer=0, index=0, both pointers=0.
REQ-027 During and after reset: rvalid=0, frame_err=0, overrun=0, rdata=8'h00.
REQ-028 After a reset released mid-frame, the remainder of that frame SHALL be ignored until a new falling edge follows a high rx_s; no flag SHALL be raised.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL control even-parity support.
REQ-030 With UART_RX_PARITY_EN defined: a PARITY state between DATA and STOP samples one bit; if (^byte ^ bit)!=0, frame_err pulses at the stop-bit sample, the byte is discarded, and no push occurs.
REQ-031 Without UART_RX_PARITY_EN: the frame is 8N1, the PARITY state does not exist, and the frame length is 10 bits.

Verification (WAIT=4, DEPTH=4, no parity unless stated)
REQ-032 Send 8'hA5 8N1 -> one cycle after the stop-sample edge, rvalid=1 and rdata=8'hA5; with rready=1, rvalid=0 next cycle.
REQ-033 Low glitch of 1 cycle on uart_rx -> no push, frame_err=0, FSM back in IDLE.
REQ-034 Send 8'h3C with the stop bit held 0 -> frame_err pulses for one cycle; rvalid stays 0.
REQ-035 rready=0; send 8'h01..8'h05 back-to-back -> 4 bytes queued, overrun pulses once on the 5th; draining yields 01,02,03,04.
REQ-036 FIFO full, rready=1 held while 8'h77 completes -> no overrun; the head pops and 8'h77 is stored as the last entry.
REQ-037 Parity build: send 8'h03 with parity bit 1 -> frame_err pulses and no push; with parity 0 -> rdata=8'h03.
